// File: rtl/latq_bank_writer_if.sv
// Write-request handshake between a register-file/config write port and the
// latch-bank writer.
interface latq_bank_writer_if #(
    parameter int AW    = 3,
    parameter int WIDTH = 8
);
    logic             wr_valid;
    logic             wr_ready;
    logic [AW-1:0]    wr_addr;
    logic [WIDTH-1:0] wr_data;

    modport master (output wr_valid, output wr_addr, output wr_data, input  wr_ready);
    modport slave  (input  wr_valid, input  wr_addr, input  wr_data, output wr_ready);
endinterface

// File: rtl/latq_bank_writer.sv
// Setup/pulse/hold write driver for a bank of transparent-high latch words.
// Optional sticky out-of-range flag: define LATQ_BANK_WRITER_ERR_EN.
module latq_bank_writer #(
    parameter int WIDTH     = 8,
    parameter int DEPTH     = 8,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 1,
    parameter int HOLD_CYC  = 1,
    parameter int AW        = $clog2(DEPTH)
) (
    input  logic                 CLK,
    input  logic                 RN,
    latq_bank_writer_if.slave    wr,
    output logic [WIDTH-1:0]     lat_d,
    output logic [DEPTH-1:0]     lat_e,
    output logic                 busy,
    output logic                 err
);

    localparam int MAX_SP = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAXC   = (MAX_SP > HOLD_CYC) ? MAX_SP : HOLD_CYC;
    localparam int CW     = $clog2(MAXC + 1);

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t           state_r, state_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [AW-1:0]    addr_r, addr_s;
    logic [WIDTH-1:0] lat_d_s;
    logic [DEPTH-1:0] lat_e_s;
    logic             ready_r;
    logic             accept_s;

    // Addresses at or beyond DEPTH decode to all-zero, so they never pulse an enable.
    function automatic logic [DEPTH-1:0] decode(input logic [AW-1:0] a);
        logic [DEPTH-1:0] d;
        d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            d[i] = (a == AW'(i));
        end
        return d;
    endfunction

    assign accept_s    = wr.wr_valid && ready_r;
    assign wr.wr_ready = ready_r;

    // Next-state, counter and next-output logic for the write sequence.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        addr_s  = addr_r;
        lat_d_s = lat_d;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SETUP;
                    cnt_s   = CW'(SETUP_CYC);
                    addr_s  = wr.wr_addr;
                    lat_d_s = wr.wr_data;
                end else begin
                    cnt_s   = '0;
                end
            end
            SETUP: begin
                if (cnt_r == CW'(1)) begin
                    state_s = PULSE;
                    cnt_s   = CW'(PULSE_CYC);
                end else begin
                    cnt_s   = cnt_r - CW'(1);
                end
            end
            PULSE: begin
                if (cnt_r == CW'(1)) begin
                    state_s = HOLD;
                    cnt_s   = CW'(HOLD_CYC);
                end else begin
                    cnt_s   = cnt_r - CW'(1);
                end
            end
            HOLD: begin
                if (cnt_r == CW'(1)) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end else begin
                    cnt_s   = cnt_r - CW'(1);
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
        // Enables come straight from flops, one-hot only while in PULSE.
        if (state_s == PULSE) begin
            lat_e_s = decode(addr_s);
        end else begin
            lat_e_s = '0;
        end
    end

    // Sequencer state, counter and captured address.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            addr_r  <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            addr_r  <= addr_s;
        end
    end

    // Registered latch bus and status outputs.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            lat_d   <= '0;
            lat_e   <= '0;
            busy    <= 1'b0;
            ready_r <= 1'b1;
        end else begin
            lat_d   <= lat_d_s;
            lat_e   <= lat_e_s;
            busy    <= (state_s != IDLE);
            ready_r <= (state_s == IDLE);
        end
    end

`ifdef LATQ_BANK_WRITER_ERR_EN
    logic err_r;

    // Sticky flag: set when an out-of-range address is accepted, cleared only by RN.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            err_r <= 1'b0;
        end else if (accept_s && (decode(wr.wr_addr) == '0)) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    assign err = err_r;
`else
    assign err = 1'b0;
`endif

endmodule
